dataset_ram_stream: RTL and testbench

//  Clocked, parametrised successor of the training-set RAM: one weight row (address 0) plus DEPTH data rows
//  (addresses 1..DEPTH), each FEAT_WIDTH*(MAX_FEATURES+1) bits wide (features plus y).

---
 rtl/minor_pkg.sv | 24 ++
 rtl/ds_skid2.sv | 62 ++++++
 rtl/dataset_ram_stream.sv | 184 ++++++++++++++++++
 tb/tb_dataset_ram_stream.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minor_pkg.sv
// Shared definitions for the training-set RAM: FSM encoding, default row geometry
// and helpers that slice a row into its feature and y fields.
package minor_pkg;

    localparam int FEAT_WIDTH   = 16;
    localparam int MAX_FEATURES = 6;
    localparam int ROW_WIDTH    = FEAT_WIDTH * (MAX_FEATURES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Feature k sits at bits [k*FEAT_WIDTH +: FEAT_WIDTH]; y is the top field.
    function automatic logic [FEAT_WIDTH-1:0] feat_field(input logic [ROW_WIDTH-1:0] row,
                                                         input int unsigned k);
        return row[k*FEAT_WIDTH +: FEAT_WIDTH];
    endfunction

    function automatic logic [FEAT_WIDTH-1:0] y_field(input logic [ROW_WIDTH-1:0] row);
        return row[ROW_WIDTH-1 -: FEAT_WIDTH];
    endfunction

endpackage

// File: rtl/ds_skid2.sv
// Two-entry valid/ready skid buffer; the producer tracks occupancy through count
// so that a 1-cycle-latency array read can be prefetched without bubbles.
module ds_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       cnt_q;
    logic             pop;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
    assign count     = cnt_q;
    assign pop       = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (in_valid) begin
                        head_q <= in_data;
                        cnt_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (in_valid && pop) begin
                        head_q <= in_data;
                    end else if (in_valid) begin
                        tail_q <= in_data;
                        cnt_q  <= 2'd2;
                    end else if (pop) begin
                        cnt_q  <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (in_valid) tail_q <= in_data;
                        else          cnt_q  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/dataset_ram_stream.sv
// Training-set RAM: weight register (row 0) plus DEPTH data rows, with a host port,
// a clear sweep and a multi-epoch valid/ready streaming engine for the trainer.
module dataset_ram_stream #(
    parameter int ADDR_WIDTH   = 3,
    parameter int MAX_FEATURES = minor_pkg::MAX_FEATURES,
    parameter int FEAT_WIDTH   = minor_pkg::FEAT_WIDTH,
    parameter int DATA_WIDTH   = FEAT_WIDTH * (MAX_FEATURES + 1),
    parameter int DEPTH        = 6,
    parameter int EPOCH_WIDTH  = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    input  logic                   wt_we,
    input  logic [DATA_WIDTH-1:0]  wt_wdata,
    output logic [DATA_WIDTH-1:0]  wt_rdata,
    input  logic                   clr_start,
    input  logic                   strm_start,
    input  logic [ADDR_WIDTH-1:0]  strm_npts,
    input  logic [EPOCH_WIDTH-1:0] strm_nepochs,
    output logic                   strm_valid,
    input  logic                   strm_ready,
    output logic [DATA_WIDTH-1:0]  strm_data,
    output logic [ADDR_WIDTH-1:0]  strm_idx,
    output logic                   strm_last,
    output logic [EPOCH_WIDTH-1:0] strm_epoch,
    output logic                   strm_done,
    output logic                   busy
);
    import minor_pkg::*;

    localparam int                     PW       = DATA_WIDTH + ADDR_WIDTH + EPOCH_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0]  LAST_ROW = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  A_ONE    = ADDR_WIDTH'(1);
    localparam logic [EPOCH_WIDTH-1:0] E_ONE    = EPOCH_WIDTH'(1);

    logic [1:0]             state;
    logic [DATA_WIDTH-1:0]  mem [1:DEPTH];
    logic [DATA_WIDTH-1:0]  wt_q;
    logic [ADDR_WIDTH-1:0]  clr_cnt;
    logic [ADDR_WIDTH-1:0]  npts_q;
    logic [EPOCH_WIDTH-1:0] nep_q;
    logic [ADDR_WIDTH-1:0]  iss_idx;
    logic [EPOCH_WIDTH-1:0] iss_ep;
    logic                   iss_more;
    logic                   fetch_v;
    logic [DATA_WIDTH-1:0]  fetch_data;
    logic [ADDR_WIDTH-1:0]  fetch_idx;
    logic [EPOCH_WIDTH-1:0] fetch_ep;
    logic                   fetch_last;
    logic [1:0]             skid_cnt;
    logic [PW-1:0]          skid_out;
    logic                   idle;
    logic                   host_wr_row;
    logic                   pop;
    logic                   issue;
    logic                   final_pop;
    logic                   drained;
    logic [ADDR_WIDTH-1:0]  npts_clamped;

    assign idle         = (state == ST_IDLE);
    assign busy         = !idle;
    assign wt_rdata     = wt_q;
    assign host_wr_row  = idle && wr_en && (wr_addr != '0) && (wr_addr <= LAST_ROW);
    assign npts_clamped = (strm_npts > LAST_ROW) ? LAST_ROW : strm_npts;
    assign pop          = strm_valid && strm_ready;
    assign final_pop    = pop && strm_last && (strm_epoch == nep_q - E_ONE);
    assign drained      = !iss_more && !fetch_v && (skid_cnt == 2'd0);

    // Issue only when the row already in flight plus the buffered rows still fit after this cycle's pop.
    assign issue = (state == ST_STREAM) && iss_more &&
                   (({1'b0, skid_cnt} + {2'b00, fetch_v} - {2'b00, pop}) < 3'd2);

    // NOTE: the row array and the weight register carry no reset so that reset
    // preserves their contents and the array can map onto RAM.
    always_ff @(posedge CLK) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (host_wr_row) begin
            mem[wr_addr] <= wr_data;
        end
        if (issue) begin
            fetch_data <= mem[iss_idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (wt_we) begin
            wt_q <= wt_wdata;
        end else if (idle && wr_en && (wr_addr == '0)) begin
            wt_q <= wr_data;
        end
    end

    // Read-first: the array sample precedes any same-edge write to the row.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en && idle;
            if (rd_en && idle) begin
                if (rd_addr == '0)          rd_data <= wt_q;
                else if (rd_addr <= LAST_ROW) rd_data <= mem[rd_addr];
                else                        rd_data <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            clr_cnt    <= '0;
            npts_q     <= '0;
            nep_q      <= '0;
            iss_idx    <= '0;
            iss_ep     <= '0;
            iss_more   <= 1'b0;
            fetch_v    <= 1'b0;
            fetch_idx  <= '0;
            fetch_ep   <= '0;
            fetch_last <= 1'b0;
            strm_done  <= 1'b0;
        end else begin
            strm_done <= (state == ST_DONE);
            fetch_v   <= issue;
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= A_ONE;
                    end else if (strm_start) begin
                        state    <= ST_STREAM;
                        npts_q   <= npts_clamped;
                        nep_q    <= strm_nepochs;
                        iss_idx  <= A_ONE;
                        iss_ep   <= '0;
                        iss_more <= (npts_clamped != '0) && (strm_nepochs != '0);
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == LAST_ROW) state <= ST_IDLE;
                    else                     clr_cnt <= clr_cnt + A_ONE;
                end
                ST_STREAM: begin
                    if (final_pop || drained) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
            if (issue) begin
                fetch_idx  <= iss_idx;
                fetch_ep   <= iss_ep;
                fetch_last <= (iss_idx == npts_q);
                if (iss_idx == npts_q) begin
                    iss_idx <= A_ONE;
                    if (iss_ep == nep_q - E_ONE) iss_more <= 1'b0;
                    else                         iss_ep   <= iss_ep + E_ONE;
                end else begin
                    iss_idx <= iss_idx + A_ONE;
                end
            end
        end
    end

    ds_skid2 #(.WIDTH(PW)) u_skid (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (fetch_v),
        .in_data   ({fetch_data, fetch_idx, fetch_ep, fetch_last}),
        .out_valid (strm_valid),
        .out_ready (strm_ready),
        .out_data  (skid_out),
        .count     (skid_cnt)
    );

    assign {strm_data, strm_idx, strm_epoch, strm_last} = skid_out;

endmodule

// File: tb/tb_dataset_ram_stream.sv
// Directed bench for dataset_ram_stream: host port, streaming with and without
// back-pressure, clamping, empty streams, weight write-back, reset abort and clear.
module tb_dataset_ram_stream;

    localparam int AW    = 3;
    localparam int EW    = 8;
    localparam int DW    = 112;
    localparam int DEPTH = 6;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wt_we = 1'b0;
    logic [DW-1:0] wt_wdata = '0;
    logic [DW-1:0] wt_rdata;
    logic          clr_start = 1'b0;
    logic          strm_start = 1'b0;
    logic [AW-1:0] strm_npts = '0;
    logic [EW-1:0] strm_nepochs = '0;
    logic          strm_valid;
    logic          strm_ready = 1'b0;
    logic [DW-1:0] strm_data;
    logic [AW-1:0] strm_idx;
    logic          strm_last;
    logic [EW-1:0] strm_epoch;
    logic          strm_done;
    logic          busy;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_row [1:DEPTH];
    logic [DW-1:0] exp_wt;

    dataset_ram_stream dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .wt_we        (wt_we),
        .wt_wdata     (wt_wdata),
        .wt_rdata     (wt_rdata),
        .clr_start    (clr_start),
        .strm_start   (strm_start),
        .strm_npts    (strm_npts),
        .strm_nepochs (strm_nepochs),
        .strm_valid   (strm_valid),
        .strm_ready   (strm_ready),
        .strm_data    (strm_data),
        .strm_idx     (strm_idx),
        .strm_last    (strm_last),
        .strm_epoch   (strm_epoch),
        .strm_done    (strm_done),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic read_row(input logic [AW-1:0] addr, input logic [DW-1:0] expv, input string name);
        rd_en = 1'b1;
        rd_addr = addr;
        cyc();
        rd_en = 1'b0;
        n_cmp++;
        if ({rd_valid, rd_data} !== {1'b1, expv}) begin
            n_bad++;
            $display("FAIL %s: got valid=%b data=%h, want valid=1 data=%h", name, rd_valid, rd_data, expv);
        end
    endtask

    task automatic test_reset();
        #1 RST_N = 1'b0;
        #2;
        n_cmp++;
        if ({rd_valid, strm_valid, strm_last, strm_done, busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000", {rd_valid, strm_valid, strm_last, strm_done, busy});
        end
        n_cmp++;
        if (rd_data !== '0) begin
            n_bad++;
            $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
        n_cmp++;
        if ({strm_data, strm_idx, strm_epoch} !== '0) begin
            n_bad++;
            $display("FAIL reset_strm: got %h/%0d/%0d want 0", strm_data, strm_idx, strm_epoch);
        end
        cyc();
        RST_N = 1'b1;
        cyc();
    endtask

    task automatic test_host_rw();
        for (int k = 1; k <= DEPTH; k++) begin
            wr_en = 1'b1;
            wr_addr = AW'(k);
            wr_data = DW'(k * 'h11);
            exp_row[k] = DW'(k * 'h11);
            cyc();
        end
        wr_addr = '0;
        wr_data = DW'('h5a5a);
        exp_wt = DW'('h5a5a);
        cyc();
        wr_en = 1'b0;
        n_cmp++;
        if (wt_rdata !== exp_wt) begin
            n_bad++;
            $display("FAIL host_wt_write: got %h want %h", wt_rdata, exp_wt);
        end
        read_row(3'd3, DW'('h33), "read_row3");
        cyc();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_valid_idle: got %b want 0", rd_valid);
        end
        read_row(3'd7, '0, "read_row7");
        read_row(3'd0, exp_wt, "read_row0");
        // Same-cycle write and read of row 2 must return the old contents.
        wr_en = 1'b1;
        wr_addr = 3'd2;
        wr_data = DW'('h99);
        read_row(3'd2, DW'('h22), "read_first");
        wr_en = 1'b0;
        read_row(3'd2, DW'('h99), "read_after_write");
        wr_en = 1'b1;
        wr_data = DW'('h22);
        cyc();
        // wt_we beats a host write to row 0.
        wr_addr = '0;
        wr_data = DW'('hbad);
        wt_we = 1'b1;
        wt_wdata = DW'('hc0de);
        exp_wt = DW'('hc0de);
        cyc();
        wr_en = 1'b0;
        wt_we = 1'b0;
        n_cmp++;
        if (wt_rdata !== exp_wt) begin
            n_bad++;
            $display("FAIL wt_we_priority: got %h want %h", wt_rdata, exp_wt);
        end
        read_row(3'd2, DW'('h22), "row2_restored");
    endtask

    task automatic run_stream(input int npts, input int nep, input bit toggle, input bit poke,
                              input string name);
        int eff;
        int total;
        int exp_idx;
        int exp_ep;
        int xfers;
        int first_c;
        int last_c;
        int done_c;
        bit hold;
        logic [DW+AW+EW+1:0] held;
        logic [DW+AW+EW:0]   expv;
        eff = (npts > DEPTH) ? DEPTH : npts;
        total = eff * nep;
        exp_idx = 1;
        exp_ep = 0;
        xfers = 0;
        first_c = -1;
        last_c = -1;
        done_c = -1;
        hold = 1'b0;
        held = '0;
        strm_npts = AW'(npts);
        strm_nepochs = EW'(nep);
        strm_start = 1'b1;
        strm_ready = 1'b0;
        cyc();
        strm_start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (strm_done) begin
                done_c = c;
                break;
            end
            if (hold) begin
                n_cmp++;
                if ({strm_valid, strm_data, strm_idx, strm_epoch, strm_last} !== held) begin
                    n_bad++;
                    $display("FAIL %s_hold c=%0d: got %h want %h", name, c,
                             {strm_valid, strm_data, strm_idx, strm_epoch, strm_last}, held);
                end
            end
            if (strm_valid && first_c < 0) first_c = c;
            strm_ready = toggle ? (c % 2 == 1) : 1'b1;
            hold = strm_valid && !strm_ready;
            held = {strm_valid, strm_data, strm_idx, strm_epoch, strm_last};
            if (strm_valid && strm_ready) begin
                n_cmp++;
                if (xfers >= total) begin
                    n_bad++;
                    $display("FAIL %s_extra_row: got idx=%0d epoch=%0d, want no row", name, strm_idx, strm_epoch);
                end else begin
                    expv = {exp_row[exp_idx], AW'(exp_idx), EW'(exp_ep), exp_idx == eff};
                    if ({strm_data, strm_idx, strm_epoch, strm_last} !== expv) begin
                        n_bad++;
                        $display("FAIL %s_row%0d: got %h want %h", name, xfers,
                                 {strm_data, strm_idx, strm_epoch, strm_last}, expv);
                    end
                end
                last_c = c;
                xfers++;
                if (exp_idx == eff) begin
                    exp_idx = 1;
                    exp_ep++;
                end else begin
                    exp_idx++;
                end
            end
            if (poke && c == 4) begin
                wt_we = 1'b1;
                wt_wdata = DW'('hfeed);
                exp_wt = DW'('hfeed);
            end else begin
                wt_we = 1'b0;
            end
            cyc();
        end
        strm_ready = 1'b0;
        wt_we = 1'b0;
        n_cmp++;
        if (done_c < 0 || xfers != total) begin
            n_bad++;
            $display("FAIL %s_count: got %0d rows done_c=%0d, want %0d rows and strm_done", name, xfers, done_c, total);
        end
        if (total > 0) begin
            n_cmp++;
            if (first_c != 2 || done_c != last_c + 2) begin
                n_bad++;
                $display("FAIL %s_timing: got first=%0d done=%0d, want first=2 done=%0d", name, first_c, done_c, last_c + 2);
            end
            if (!toggle) begin
                n_cmp++;
                if (last_c - first_c != total - 1) begin
                    n_bad++;
                    $display("FAIL %s_bubbles: got span %0d, want %0d", name, last_c - first_c, total - 1);
                end
            end
        end else begin
            n_cmp++;
            if (first_c != -1 || done_c != 2) begin
                n_bad++;
                $display("FAIL %s_empty: got first=%0d done=%0d, want first=-1 done=2", name, first_c, done_c);
            end
        end
        cyc();
        n_cmp++;
        if ({strm_done, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s_pulse: got done=%b busy=%b, want 0 0", name, strm_done, busy);
        end
        if (poke) begin
            n_cmp++;
            if (wt_rdata !== exp_wt) begin
                n_bad++;
                $display("FAIL %s_wt: got %h want %h", name, wt_rdata, exp_wt);
            end
        end
    endtask

    task automatic test_midstream_reset();
        bit saw_done;
        saw_done = 1'b0;
        strm_npts = 3'd6;
        strm_nepochs = 8'd3;
        strm_start = 1'b1;
        strm_ready = 1'b1;
        cyc();
        strm_start = 1'b0;
        repeat (5) cyc();
        #1 RST_N = 1'b0;
        #1;
        n_cmp++;
        if ({strm_valid, strm_last, strm_done, busy, rd_valid, strm_data, strm_idx, strm_epoch} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got valid=%b busy=%b idx=%0d epoch=%0d, want all 0",
                     strm_valid, busy, strm_idx, strm_epoch);
        end
        strm_ready = 1'b0;
        cyc();
        RST_N = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (strm_done) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_no_done: got strm_done pulse, want none");
        end
        for (int k = 1; k <= DEPTH; k++) read_row(AW'(k), exp_row[k], "midreset_row");
        read_row(3'd0, exp_wt, "midreset_wt");
    endtask

    task automatic test_clear_priority();
        int  busy_cnt;
        bit  any_rdv;
        bit  any_sv;
        busy_cnt = 0;
        any_rdv = 1'b0;
        any_sv = 1'b0;
        clr_start = 1'b1;
        strm_start = 1'b1;
        strm_npts = 3'd4;
        strm_nepochs = 8'd1;
        strm_ready = 1'b1;
        cyc();
        clr_start = 1'b0;
        strm_start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (busy) busy_cnt++;
            if (rd_valid) any_rdv = 1'b1;
            if (strm_valid) any_sv = 1'b1;
            rd_en = busy;
            rd_addr = 3'd1;
            cyc();
        end
        rd_en = 1'b0;
        strm_ready = 1'b0;
        n_cmp++;
        if (busy_cnt != DEPTH || any_rdv || any_sv) begin
            n_bad++;
            $display("FAIL clear_busy: got busy=%0d rd_valid_seen=%b strm_valid_seen=%b, want %0d 0 0",
                     busy_cnt, any_rdv, any_sv, DEPTH);
        end
        for (int k = 1; k <= DEPTH; k++) begin
            exp_row[k] = '0;
            read_row(AW'(k), '0, "clear_row");
        end
        read_row(3'd0, exp_wt, "clear_wt");
    endtask

    initial begin
        test_reset();
        test_host_rw();
        run_stream(4, 2, 1'b0, 1'b0, "stream_4x2");
        run_stream(4, 2, 1'b1, 1'b0, "stream_4x2_stall");
        run_stream(7, 1, 1'b0, 1'b0, "stream_clamp");
        run_stream(0, 3, 1'b0, 1'b0, "stream_npts0");
        run_stream(3, 0, 1'b0, 1'b0, "stream_nep0");
        run_stream(6, 1, 1'b0, 1'b1, "stream_wt_poke");
        test_midstream_reset();
        test_clear_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
